// File: rtl/paddle_tracker.sv
// paddle_tracker: paddles the ADC, block-averages the 8-bit samples, clamps the
// result to the playfield and slews the published paddle Y once per frame.
module paddle_tracker #(
  parameter int ADC_DIV  = 2,
  parameter int AVG_LOG2 = 3,
  parameter int Y_MIN    = 8,
  parameter int Y_MAX    = 408,
  parameter int SLEW     = 4
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic [7:0]  adc_d,
  input  logic        vsync,
  output logic        adc_clk,
  output logic [8:0]  avg,
  output logic        avg_valid,
  output logic [10:0] paddle_y
);

  localparam int CW = $clog2(ADC_DIV);
  localparam int AW = 8 + AVG_LOG2;

  localparam logic [CW-1:0]       CNT_LAST = CW'(ADC_DIV - 1);
  localparam logic [CW-1:0]       CNT_HALF = CW'(ADC_DIV / 2);
  localparam logic [AVG_LOG2-1:0] N_LAST   = '1;
  localparam logic [10:0]         Y_LO     = 11'(Y_MIN);
  localparam logic [10:0]         Y_HI     = 11'(Y_MAX);
  localparam logic [10:0]         Y_MID    = 11'((Y_MIN + Y_MAX) / 2);
  localparam logic [10:0]         SLEW_U   = 11'(SLEW);
  localparam logic signed [11:0]  SLEW_S   = 12'(SLEW);

  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nxt;
  logic                strobe;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       sum;
  logic [AVG_LOG2-1:0] n;
  logic [8:0]          avg_nxt;
  logic [10:0]         target;
  logic [10:0]         target_nxt;
  logic                vsync_q;
  logic                frame_edge;
  logic signed [11:0]  d;
  logic [10:0]         paddle_nxt;

  // Divider step, block sum, scaled average, clamp and slew decision.
  always_comb begin
    cnt_nxt    = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    strobe     = (cnt == '0);
    sum        = acc + AW'(adc_d);
    avg_nxt    = 9'(sum >> (AVG_LOG2 - 1));
    target_nxt = {2'b00, avg_nxt};
    if ({2'b00, avg_nxt} < Y_LO) begin
      target_nxt = Y_LO;
    end else if ({2'b00, avg_nxt} > Y_HI) begin
      target_nxt = Y_HI;
    end
    frame_edge = vsync & ~vsync_q;
    d          = $signed({1'b0, target}) - $signed({1'b0, paddle_y});
    paddle_nxt = target;
    if (d > SLEW_S) begin
      paddle_nxt = paddle_y + SLEW_U;
    end else if (d < -SLEW_S) begin
      paddle_nxt = paddle_y - SLEW_U;
    end
  end

  // ADC clock generation and block accumulation of samples.
  // adc_clk is registered from the next count so it tracks cnt cycle for cycle.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      cnt       <= '0;
      adc_clk   <= 1'b0;
      acc       <= '0;
      n         <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
      target    <= Y_MID;
    end else begin
      cnt       <= cnt_nxt;
      adc_clk   <= (cnt_nxt >= CNT_HALF);
      avg_valid <= 1'b0;
      if (strobe) begin
        if (n == N_LAST) begin
          acc       <= '0;
          n         <= '0;
          avg       <= avg_nxt;
          target    <= target_nxt;
          avg_valid <= 1'b1;
        end else begin
          acc <= sum;
          n   <= n + AVG_LOG2'(1);
        end
      end
    end
  end

  // Frame-edge detection and once-per-frame slew of the published position.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      vsync_q  <= 1'b1;
      paddle_y <= Y_MID;
    end else begin
      vsync_q <= vsync;
      if (frame_edge) begin
        paddle_y <= paddle_nxt;
      end
    end
  end

endmodule

// File: tb/tb_paddle_tracker.sv
// tb_paddle_tracker: directed, table-driven bench for paddle_tracker (defaults).
module tb_paddle_tracker;

  logic        clk;
  logic        reset;
  logic [7:0]  adc_d;
  logic        vsync;
  logic        adc_clk;
  logic [8:0]  avg;
  logic        avg_valid;
  logic [10:0] paddle_y;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sel;     // sample k uses b when sel[k] is set, else a
    int         exp_avg;
    int         exp_py;  // paddle_y after one frame edge from 208
  } vec_t;

  vec_t vecs[11];

  paddle_tracker #(
    .ADC_DIV (2),
    .AVG_LOG2(3),
    .Y_MIN   (8),
    .Y_MAX   (408),
    .SLEW    (4)
  ) dut (
    .pixel_clock(clk),
    .reset      (reset),
    .adc_d      (adc_d),
    .vsync      (vsync),
    .adc_clk    (adc_clk),
    .avg        (avg),
    .avg_valid  (avg_valid),
    .paddle_y   (paddle_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 after release: cnt==0, block start.
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic frame();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
  endtask

  // Waits for the next avg_valid, then steps to the following block start.
  task automatic align();
    int c;
    c = 0;
    while (!avg_valid && c < 40) begin
      tick();
      c++;
    end
    check("align valid", avg_valid, 1);
    tick();
  endtask

  // Must start at a block start; ends in the cycle where avg_valid is visible.
  task automatic feed_block(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] sel, input int exp_avg,
                            input bit vs_final, input string nm);
    for (int k = 0; k < 8; k++) begin
      adc_d = sel[k] ? b : a;
      if (k == 7 && vs_final) vsync = 1'b1;
      tick();
      if (k < 7) tick();
    end
    check({nm, " avg_valid"}, avg_valid, 1);
    check({nm, " avg"}, avg, exp_avg);
  endtask

  initial begin
    int exp_py;
    int lat;

    vecs[0]  = '{a:8'd100, b:8'd100, sel:8'h00, exp_avg:200, exp_py:204};
    vecs[1]  = '{a:8'd255, b:8'd255, sel:8'h00, exp_avg:510, exp_py:212};
    vecs[2]  = '{a:8'd2,   b:8'd2,   sel:8'h00, exp_avg:4,   exp_py:204};
    vecs[3]  = '{a:8'd99,  b:8'd100, sel:8'hAA, exp_avg:199, exp_py:204};
    vecs[4]  = '{a:8'd50,  b:8'd50,  sel:8'h00, exp_avg:100, exp_py:204};
    vecs[5]  = '{a:8'd0,   b:8'd255, sel:8'hAA, exp_avg:255, exp_py:212};
    vecs[6]  = '{a:8'd0,   b:8'd7,   sel:8'h01, exp_avg:1,   exp_py:204};
    vecs[7]  = '{a:8'd0,   b:8'd255, sel:8'h07, exp_avg:191, exp_py:204};
    vecs[8]  = '{a:8'd105, b:8'd105, sel:8'h00, exp_avg:210, exp_py:210};
    vecs[9]  = '{a:8'd103, b:8'd103, sel:8'h00, exp_avg:206, exp_py:206};
    vecs[10] = '{a:8'd106, b:8'd106, sel:8'h00, exp_avg:212, exp_py:212};

    reset = 1'b1;
    adc_d = 8'd0;
    vsync = 1'b0;

    // Reset state and free-running behaviour with vsync held low.
    do_reset();
    check("reset avg", avg, 0);
    check("reset avg_valid", avg_valid, 0);
    for (int c = 0; c < 40; c++) begin
      check($sformatf("adc_clk c%0d", c), adc_clk, c % 2);
      check($sformatf("avg_valid c%0d", c), avg_valid, (c % 16 == 15) ? 1 : 0);
      check($sformatf("idle paddle_y c%0d", c), paddle_y, 208);
      tick();
    end

    // vsync high across reset release must not produce a frame edge.
    vsync = 1'b1;
    adc_d = 8'd255;
    do_reset();
    for (int c = 0; c < 20; c++) tick();
    check("vsync high at release", paddle_y, 208);
    vsync = 1'b0;

    // Table: one block from reset, then one frame edge.
    for (int i = 0; i < 11; i++) begin
      do_reset();
      feed_block(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp_avg, 1'b0,
                 $sformatf("vec%0d", i));
      frame();
      check($sformatf("vec%0d paddle_y", i), paddle_y, vecs[i].exp_py);
    end

    // Constant 100: 208 -> 204 -> 200, then holds.
    do_reset();
    feed_block(8'd100, 8'd100, 8'h00, 200, 1'b0, "c100");
    for (int f = 1; f <= 4; f++) begin
      frame();
      exp_py = (f == 1) ? 204 : 200;
      check($sformatf("c100 frame%0d", f), paddle_y, exp_py);
    end

    // Constant 255: climbs 4 per frame, reaches 408 on frame 50.
    do_reset();
    feed_block(8'd255, 8'd255, 8'h00, 510, 1'b0, "c255");
    for (int f = 1; f <= 52; f++) begin
      frame();
      exp_py = (208 + 4 * f > 408) ? 408 : 208 + 4 * f;
      check($sformatf("c255 frame%0d", f), paddle_y, exp_py);
    end

    // Constant 2: falls 4 per frame, reaches 8 on frame 50.
    do_reset();
    feed_block(8'd2, 8'd2, 8'h00, 4, 1'b0, "c2");
    for (int f = 1; f <= 52; f++) begin
      frame();
      exp_py = (208 - 4 * f < 8) ? 8 : 208 - 4 * f;
      check($sformatf("c2 frame%0d", f), paddle_y, exp_py);
    end

    // Frame edge on the final-sample cycle: slew uses the old target (200).
    do_reset();
    feed_block(8'd100, 8'd100, 8'h00, 200, 1'b0, "coin pre");
    tick();
    frame();
    frame();
    check("coin settle", paddle_y, 200);
    align();
    feed_block(8'd150, 8'd150, 8'h00, 300, 1'b1, "coin");
    check("coin same edge", paddle_y, 200);
    vsync = 1'b0;
    tick();
    frame();
    check("coin next edge", paddle_y, 204);

    // Reset after 5 samples of 255 discards the partial block.
    align();
    adc_d = 8'd255;
    for (int c = 0; c < 9; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    adc_d = 8'd50;
    check("midreset paddle_y", paddle_y, 208);
    check("midreset avg", avg, 0);
    check("midreset avg_valid", avg_valid, 0);
    lat = 0;
    while (!avg_valid && lat < 40) begin
      tick();
      lat++;
    end
    // Cycle index 15 is the 16th cycle after release.
    check("midreset latency", lat, 15);
    check("midreset avg", avg, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
